// File: rtl/wb_pkg.sv
// Shared types and encodings for the register-file write-back path.
package wb_pkg;

    localparam int XLEN = 32;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // One outstanding load; 'last' marks the youngest load to this rd
    typedef struct packed {
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [1:0] addr_lo;
        logic       last;
    } ldq_entry_t;

endpackage

// File: rtl/load_formatter.sv
// Extracts and extends the addressed byte/halfword/word of a raw load word.
module load_formatter
    import wb_pkg::*;
#(
    parameter int XLEN = wb_pkg::XLEN
) (
    input  logic [XLEN-1:0] raw,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    output logic [XLEN-1:0] data
);

    function automatic logic [XLEN-1:0] ext8(input logic [7:0] b, input logic sgn);
        return {{(XLEN-8){sgn & b[7]}}, b};
    endfunction

    function automatic logic [XLEN-1:0] ext16(input logic [15:0] h, input logic sgn);
        return {{(XLEN-16){sgn & h[15]}}, h};
    endfunction

    logic [7:0]  sel_b;
    logic [15:0] sel_h;

    // Select the lane and apply sign or zero extension by funct3
    always_comb begin
        sel_b = raw[{addr_lo, 3'b000} +: 8];
        sel_h = raw[{addr_lo[1], 4'b0000} +: 16];
        data  = '0;
        case (funct3)
            F3_LB:   data = ext8(sel_b, 1'b1);
            F3_LBU:  data = ext8(sel_b, 1'b0);
            F3_LH:   data = ext16(sel_h, 1'b1);
            F3_LHU:  data = ext16(sel_h, 1'b0);
            F3_LW:   data = raw;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/reg_writeback.sv
// Register-file write driver: arbitrates ALU results against in-order load
// returns, tracks outstanding loads and exports a per-register busy map.
module reg_writeback
    import wb_pkg::*;
#(
    parameter int LDQ_DEPTH = 2,
    parameter int XLEN      = wb_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            ld_issue_valid,
    input  logic [4:0]      ld_issue_rd,
    input  logic [2:0]      ld_issue_funct3,
    input  logic [1:0]      ld_issue_addr_lo,
    output logic            ld_issue_ready,
    input  logic            ld_resp_valid,
    input  logic [XLEN-1:0] ld_resp_data,
    output logic            ld_resp_ready,
    output logic [31:0]     busy,
    output logic            reg_write,
    output logic [4:0]      write_reg,
    output logic [XLEN-1:0] write_data
);

    localparam int PTR_W = $clog2(LDQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    ldq_entry_t       ldq [LDQ_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] q_cnt;
    logic             q_empty, q_full;

    // Skid slot: one response waiting for its write-back cycle
    logic             vld_p1;
    ldq_entry_t       skid_ent_p1;
    logic [XLEN-1:0]  skid_raw_p1;
    logic [XLEN-1:0]  fmt_data;

    logic [31:0]      busy_q, busy_n;
    logic             err_ldq;
    logic             resp_acc, resp_pop, issue_acc, alu_acc;
    ldq_entry_t       issue_ent, head_ent;

    assign q_empty        = (q_cnt == '0);
    assign q_full         = (q_cnt == CNT_W'(LDQ_DEPTH));
    assign ld_resp_ready  = !vld_p1;
    assign resp_acc       = ld_resp_valid && !vld_p1;
    assign resp_pop       = resp_acc && !q_empty;
    assign ld_issue_ready = !q_full || resp_pop;
    assign issue_acc      = ld_issue_valid && ld_issue_ready;
    assign alu_ready      = !vld_p1 && !(busy_q[alu_rd] && (alu_rd != 5'd0));
    assign alu_acc        = alu_valid && alu_ready;
    assign busy           = busy_q;
    assign issue_ent      = '{rd: ld_issue_rd, funct3: ld_issue_funct3,
                              addr_lo: ld_issue_addr_lo, last: 1'b1};

    // Head entry loses its last-writer flag if a newer load to the same rd issues now
    always_comb begin
        head_ent = ldq[rd_ptr];
        if (issue_acc && (ld_issue_rd == head_ent.rd))
            head_ent.last = 1'b0;
    end

    // Busy map: clear on the last writer's drain, a same-cycle issue wins
    always_comb begin
        busy_n = busy_q;
        if (vld_p1 && skid_ent_p1.last)
            busy_n[skid_ent_p1.rd] = 1'b0;
        if (issue_acc)
            busy_n[ld_issue_rd] = 1'b1;
        busy_n[0] = 1'b0;
    end

    // Queue storage: a new issue demotes older entries with the same rd
    always_ff @(posedge clk) begin
        if (issue_acc) begin
            for (int i = 0; i < LDQ_DEPTH; i++) begin
                if (ldq[i].rd == ld_issue_rd)
                    ldq[i].last <= 1'b0;
            end
            ldq[wr_ptr] <= issue_ent;
        end
    end

    // Stage p1: capture the popped head and raw response into the skid slot
    always_ff @(posedge clk) begin
        if (resp_pop) begin
            skid_ent_p1 <= head_ent;
            skid_raw_p1 <= ld_resp_data;
        end
    end

    // Queue pointers, occupancy, skid valid, busy map and protocol error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_cnt   <= '0;
            vld_p1  <= 1'b0;
            busy_q  <= '0;
            err_ldq <= 1'b0;
        end else begin
            if (issue_acc)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (resp_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({issue_acc, resp_pop})
                2'b10:   q_cnt <= q_cnt + CNT_W'(1);
                2'b01:   q_cnt <= q_cnt - CNT_W'(1);
                default: q_cnt <= q_cnt;
            endcase
            vld_p1 <= resp_pop;
            busy_q <= busy_n;
            if (resp_acc && q_empty)
                err_ldq <= 1'b1;
        end
    end

    load_formatter #(.XLEN(XLEN)) u_fmt (
        .raw     (skid_raw_p1),
        .funct3  (skid_ent_p1.funct3),
        .addr_lo (skid_ent_p1.addr_lo),
        .data    (fmt_data)
    );

    // Stage p2: registered register-file write port, skid entry beats the ALU
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write  <= 1'b0;
            write_reg  <= 5'd0;
            write_data <= '0;
        end else if (vld_p1) begin
            reg_write  <= (skid_ent_p1.rd != 5'd0);
            write_reg  <= skid_ent_p1.rd;
            write_data <= fmt_data;
        end else if (alu_acc) begin
            reg_write  <= (alu_rd != 5'd0);
            write_reg  <= alu_rd;
            write_data <= alu_data;
        end else begin
            reg_write  <= 1'b0;
        end
    end

endmodule
